pfxunsum: RTL
=============

# pfxunsum

Inverse of the Blelloch exclusive prefix-sum block: it takes an exclusive-scan vector plus the scan total and recovers the original element vector in place. It runs the scan's two sweeps backwards: first the down-sweep undone level by level, then the zeroed tail element restored from the total, then the up-sweep undone. It sits on the output side of the scan block and is used to verify the scan round trip and to decode scan-encoded data. All arithmetic is modulo 2^IWIDTH.

## Interface
- IWIDTH, 8: element width in bits.
- V_LEN, 16: vector length; must be a power of two and at least 2. Let L = log2(V_LEN).

- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- valid_in  in  1  load request; sampled only while in_ready=1.
- ivec  in  V_LEN*IWIDTH  exclusive prefix-sum vector; element n is at bits [(n+1)*IWIDTH-1 : n*IWIDTH].
- itotal  in  IWIDTH  inclusive total, i.e. the sum of all original elements mod 2^IWIDTH.
- in_ready  out  1  high in IDLE and DONE.
- valid_out  out  1  high while ovec holds a finished result.
- ovec  out  V_LEN*IWIDTH  recovered original vector, same packing as ivec.

## Operation
- Internal array vec[0..V_LEN-1] of IWIDTH bits, a total register, and a level counter sized for 0..L-1.
- States and transitions:
  - IDLE: in_ready=1. On valid_in, load vec from ivec and total from itotal, set level=0, go to UNDOWN.
  - UNDOWN: for every n with n % 2^(level+1) == 0 and r = n + 2^(level+1) - 1 < V_LEN, with l = n + 2^level - 1:
    - vec[r] <= vec[l]
    - vec[l] <= vec[r] - vec[l]
    - Both right-hand sides use pre-edge values.
    - If level == L-1, go to RESTORE; otherwise level+1.
  - RESTORE: vec[V_LEN-1] <= total; level <= L-1; go to UNUP.
  - UNUP: for the same (l, r) pairs at the current level, vec[r] <= vec[r] - vec[l].
    - If level == 0, go to DONE; in the same edge, ovec <= the post-update vec and valid_out <= 1.
    - Otherwise level-1.
  - DONE: valid_out=1; ovec and vec are held. in_ready=1. On valid_in, load as in IDLE, clear valid_out, go to UNDOWN.
- Subtraction wraps modulo 2^IWIDTH with no saturation and no overflow flag. Modular arithmetic makes the inverse exact for any input produced by the forward scan.
- valid_in while in UNDOWN, RESTORE or UNUP is ignored: no load, no state change, no error.
- Inputs that are not a consistent scan are still processed deterministically by the rules above; there is no detection.

## Timing
- Reset (rst_n=0 at an edge) has priority over everything. Results after reset:
  - state=IDLE, valid_out=0, ovec=0, vec=0, level=0, in_ready=1.
  - A reset mid-operation discards the job.
- Accept edge E0 (valid_in=1, in_ready=1). Then:
  - Edges E1..EL: UNDOWN, levels 0..L-1.
  - Edge EL+1: RESTORE.
  - Edges EL+2..E2L+1: UNUP, levels L-1..0.
- valid_out and ovec are valid after E2L+1, giving a latency of 2L+1 cycles. For V_LEN=16 this is 9 cycles; for V_LEN=2 it is 3.
- in_ready drops after E0 and rises after E2L+1.
- Back-to-back: valid_in held high across E2L+2 is accepted at that edge. valid_out drops after E2L+2, so it is high for exactly one cycle in the back-to-back case. Throughput is one vector per 2L+2 cycles.
- ovec changes only on the completing edge or on reset.

## Test plan
- Ramp, V_LEN=16, IWIDTH=8: ivec={0,1,3,6,10,15,21,28,36,45,55,66,78,91,105,120}, itotal=136 -> valid_out rises 9 cycles after accept; ovec={1,2,...,16}.
- Wrap: ivec[n]=(256-n)%256, i.e. {0,255,254,...,241}, itotal=240 -> ovec = sixteen 0xFF.
- Minimum size, V_LEN=2: ivec={0,5}, itotal=12 -> ovec={5,7} after 3 cycles.
- Busy drop: accept the ramp, then pulse valid_in with the all-zero vector at cycles 2 and 5 -> the ramp result is unchanged and in_ready stays 0 until valid_out.
- Reset mid-op: rst_n=0 for 1 cycle at cycle 4 of a job -> next cycle valid_out=0, ovec=0, in_ready=1. A fresh ramp job then completes correctly in 9 cycles.
- Back-to-back: ramp then wrap with valid_in held high -> valid_out is high for one cycle with the ramp result, then low for 9 cycles, then the wrap result, which holds until the next accept.

Source files
------------

// File: rtl/pfxunsum.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pfxunsum: inverts a Blelloch exclusive scan back to its elements.    |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module pfxunsum #(
    parameter int IWIDTH = 8,
    parameter int V_LEN  = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      valid_in,
    input  logic [V_LEN*IWIDTH-1:0]   ivec,
    input  logic [IWIDTH-1:0]         itotal,
    output logic                      in_ready,
    output logic                      valid_out,
    output logic [V_LEN*IWIDTH-1:0]   ovec
);

    localparam int L   = $clog2(V_LEN);
    localparam int LVW = (L > 1) ? $clog2(L) : 1;
    localparam logic [LVW-1:0] LAST = LVW'(L - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        UNDOWN  = 3'd1,
        RESTORE = 3'd2,
        UNUP    = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t                    state_q;
    logic [LVW-1:0]            level_q;
    logic [IWIDTH-1:0]         total_q;
    logic [IWIDTH-1:0]         vec_q      [V_LEN];
    logic [IWIDTH-1:0]         ivec_a     [V_LEN];
    logic [IWIDTH-1:0]         vec_dn_d   [V_LEN];
    logic [IWIDTH-1:0]         vec_up_d   [V_LEN];
    logic [V_LEN*IWIDTH-1:0]   vec_up_flat;
    logic [V_LEN*IWIDTH-1:0]   ovec_q;
    logic                      valid_out_q;

    genvar gi;
    generate
        for (gi = 0; gi < V_LEN; gi++) begin : g_pack
            assign ivec_a[gi]                          = ivec[gi*IWIDTH +: IWIDTH];
            assign vec_up_flat[gi*IWIDTH +: IWIDTH]    = vec_up_d[gi];
        end
    endgenerate

    // Both sweeps read only pre-edge vec_q, so every pair at a level updates in parallel.
    always_comb begin
        vec_dn_d = vec_q;
        vec_up_d = vec_q;
        for (int lv = 0; lv < L; lv++) begin
            if (level_q == LVW'(lv)) begin
                for (int n = 0; n < V_LEN; n += (2 << lv)) begin
                    vec_dn_d[n + (2 << lv) - 1] = vec_q[n + (1 << lv) - 1];
                    vec_dn_d[n + (1 << lv) - 1] = vec_q[n + (2 << lv) - 1]
                                                - vec_q[n + (1 << lv) - 1];
                    vec_up_d[n + (2 << lv) - 1] = vec_q[n + (2 << lv) - 1]
                                                - vec_q[n + (1 << lv) - 1];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            level_q     <= '0;
            total_q     <= '0;
            vec_q       <= '{default: '0};
            ovec_q      <= '0;
            valid_out_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (valid_in) begin
                        vec_q       <= ivec_a;
                        total_q     <= itotal;
                        level_q     <= '0;
                        valid_out_q <= 1'b0;
                        state_q     <= UNDOWN;
                    end
                end
                UNDOWN: begin
                    vec_q <= vec_dn_d;
                    if (level_q == LAST) begin
                        state_q <= RESTORE;
                    end else begin
                        level_q <= level_q + LVW'(1);
                    end
                end
                RESTORE: begin
                    vec_q[V_LEN-1] <= total_q;
                    level_q        <= LAST;
                    state_q        <= UNUP;
                end
                UNUP: begin
                    vec_q <= vec_up_d;
                    if (level_q == '0) begin
                        ovec_q      <= vec_up_flat;
                        valid_out_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        level_q <= level_q - LVW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE) || (state_q == DONE);
    assign valid_out = valid_out_q;
    assign ovec      = ovec_q;

endmodule
`default_nettype wire
